// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone incrementing-burst master with per-beat ack timeout
module wb_burst_master #(
    parameter int DW  = 32,
    parameter int BL  = 5,
    parameter int TMO = 255
) (
    input  logic            sys_clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [25:0]     cmd_addr,
    input  logic [BL-1:0]   cmd_len,
    input  logic            wdat_valid,
    input  logic [DW-1:0]   wdat,
    output logic            wdat_ready,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [25:0]     wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);
    localparam int TW = $clog2(TMO + 1);
    typedef enum logic [1:0] {IDLE, BURST, END} state_t;
    state_t        state;
    logic [BL-1:0] rem;
    logic [TW-1:0] tmo_cnt;
    logic          beat;
    assign wb_stb_o   = wb_cyc_o && (!wb_we_o || wdat_valid);
    assign beat       = wb_stb_o && wb_ack_i;
    assign wb_dat_o   = wdat;
    assign wdat_ready = beat && wb_we_o;
    assign cmd_ready  = resetn && state == IDLE;
    // Burst sequencing: rem counts beats left, so the final beat is rem==1 and cti can be staged one beat early
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rem        <= '0;
            tmo_cnt    <= '0;
            wb_cyc_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= '0;
            wb_sel_o   <= '0;
            wb_cti_o   <= 3'b000;
            rdat_valid <= 1'b0;
            rdat       <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            rdat_valid <= beat && !wb_we_o;
            if (beat && !wb_we_o) rdat <= wb_dat_i;
            case (state)
                IDLE: if (cmd_valid) begin
                    state     <= BURST;
                    wb_cyc_o  <= 1'b1;
                    wb_we_o   <= cmd_we;
                    wb_addr_o <= cmd_addr;
                    wb_sel_o  <= '1;
                    rem       <= (cmd_len == '0) ? BL'(1) : cmd_len;
                    wb_cti_o  <= (cmd_len > BL'(1)) ? 3'b010 : 3'b000;
                    tmo_cnt   <= '0;
                end
                BURST: if (beat) begin
                    tmo_cnt <= '0;
                    if (rem == BL'(1)) begin
                        state    <= END;
                        wb_cyc_o <= 1'b0;
                        wb_sel_o <= '0;
                        wb_cti_o <= 3'b000;
                        done     <= 1'b1;
                    end else begin
                        rem       <= rem - BL'(1);
                        wb_addr_o <= wb_addr_o + 26'(DW / 8);
                        wb_cti_o  <= (rem == BL'(2)) ? 3'b111 : 3'b010;
                    end
                end else if (wb_stb_o) begin
                    if (tmo_cnt == TW'(TMO - 1)) begin
                        state    <= IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_sel_o <= '0;
                        wb_cti_o <= 3'b000;
                        err      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
